// File: rtl/axi_rd_arb_pkg.sv
// Shared types and constants for the AXI read-channel arbiter.
// Optional QoS arbitration is enabled with the AXI_RD_ARB_QOS_EN macro.
package axi_rd_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    localparam logic [2:0] AXI_SIZE_16B   = 3'b100;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam int         RID_W          = 4;
    localparam int         CNT_W          = 4;

endpackage

// File: rtl/axi_rd_arb_if.sv
// Slave-facing AXI read port (AR + R) of the arbiter, 128-bit data.
// Handshake: a beat transfers on a rising clock edge where valid and ready are both high.
interface axi_rd_arb_if;
    import axi_rd_arb_pkg::*;

    logic             arvalid;
    logic             arready;
    logic [RID_W-1:0] arid;
    logic [31:0]      araddr;
    logic [5:0]       arlen;
    logic [2:0]       arsize;
    logic [1:0]       arburst;
    logic [3:0]       arqos;
    logic             rvalid;
    logic             rready;
    logic [RID_W-1:0] rid;
    logic [127:0]     rdata;
    logic             rlast;
    logic [1:0]       rresp;

    modport master (
        output arvalid, arid, araddr, arlen, arsize, arburst, arqos, rready,
        input  arready, rvalid, rid, rdata, rlast, rresp
    );

    modport slave (
        input  arvalid, arid, araddr, arlen, arsize, arburst, arqos, rready,
        output arready, rvalid, rid, rdata, rlast, rresp
    );

endinterface

// File: rtl/axi_rd_arb_rr_pick.sv
// Round-robin picker: first set bit of i_eligible at or after i_ptr, wrapping.
// Purely combinational; shared by read- and write-side arbiters.
module axi_rd_arb_rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  i_eligible,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_any,
    output logic [NREQ-1:0]  o_grant_oh,
    output logic [IDX_W-1:0] o_grant_idx
);

    logic [IDX_W-1:0] w_c;

    always_comb begin
        o_any       = 1'b0;
        o_grant_oh  = '0;
        o_grant_idx = '0;
        w_c         = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_c = IDX_W'((int'(i_ptr) + k) % NREQ);
            if (!o_any && i_eligible[w_c]) begin
                o_any       = 1'b1;
                o_grant_oh  = NREQ'(1) << w_c;
                o_grant_idx = w_c;
            end
        end
    end

endmodule

// File: rtl/axi_rd_arb.sv
// Round-robin arbiter sharing one AXI read port among NREQ requesters, arid = requester index.
// Define AXI_RD_ARB_QOS_EN to restrict each arbitration to the highest-QoS eligible requesters.
module axi_rd_arb
    import axi_rd_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int MAX_OUT = 4
) (
    input  logic              aclk,
    input  logic              arst,
    input  logic [NREQ-1:0]   req_arvalid,
    input  logic [NREQ*32-1:0] req_araddr,
    input  logic [NREQ*6-1:0] req_arlen,
    input  logic [NREQ*4-1:0] req_arqos,
    output logic [NREQ-1:0]   req_arready,
    output logic [NREQ-1:0]   req_rvalid,
    input  logic [NREQ-1:0]   req_rready,
    output logic [127:0]      req_rdata,
    output logic              req_rlast,
    output logic [1:0]        req_rresp,
    axi_rd_arb_if.master      m_axi,
    output logic              err_rid,
    output state_e            o_dbg_state
);

    localparam int IDX_W = $clog2(NREQ);

    state_e           r_state;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] r_grant;
    logic [NREQ-1:0]  r_grant_oh;
    logic             r_arvalid;
    logic [31:0]      r_araddr;
    logic [5:0]       r_arlen;
    logic [CNT_W-1:0] r_out_cnt [NREQ];
    logic             r_err_rid;

    logic [31:0]      w_addr [NREQ];
    logic [5:0]       w_len  [NREQ];
    logic [NREQ-1:0]  w_eligible;
    logic [NREQ-1:0]  w_cand;
    logic             w_any;
    logic [NREQ-1:0]  w_grant_oh;
    logic [IDX_W-1:0] w_grant_idx;
    logic             w_ar_hs;
    logic             w_rid_ok;
    logic             w_r_last_hs;
    logic [15:0]      w_rdy_pad;
    logic [NREQ-1:0]  w_inc;
    logic [NREQ-1:0]  w_dec;

    for (genvar i = 0; i < NREQ; i++) begin : g_req
        assign w_addr[i]     = req_araddr[32*i +: 32];
        assign w_len[i]      = req_arlen[6*i +: 6];
        assign w_eligible[i] = req_arvalid[i] && (r_out_cnt[i] != CNT_W'(MAX_OUT));
        assign req_rvalid[i] = m_axi.rvalid && (m_axi.rid == RID_W'(i));
        assign w_dec[i]      = w_r_last_hs && (m_axi.rid == RID_W'(i));
    end

`ifdef AXI_RD_ARB_QOS_EN
    logic [3:0] w_qos [NREQ];
    logic [3:0] w_max_qos;
    logic [3:0] r_arqos;

    for (genvar i = 0; i < NREQ; i++) begin : g_qos
        assign w_qos[i] = req_arqos[4*i +: 4];
    end

    // Only the top QoS level among eligible requesters enters round-robin.
    always_comb begin
        w_max_qos = '0;
        w_cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_eligible[i] && (w_qos[i] > w_max_qos)) w_max_qos = w_qos[i];
        end
        for (int i = 0; i < NREQ; i++) begin
            w_cand[i] = w_eligible[i] && (w_qos[i] == w_max_qos);
        end
    end

    assign m_axi.arqos = r_arqos;
`else
    logic w_unused_qos;
    assign w_unused_qos = ^req_arqos;
    assign w_cand       = w_eligible;
    assign m_axi.arqos  = 4'd0;
`endif

    axi_rd_arb_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_eligible  (w_cand),
        .i_ptr       (r_rr_ptr),
        .o_any       (w_any),
        .o_grant_oh  (w_grant_oh),
        .o_grant_idx (w_grant_idx)
    );

    assign w_ar_hs = (r_state == ISSUE) && m_axi.arready;
    assign w_inc   = {NREQ{w_ar_hs}} & r_grant_oh;

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_grant    <= '0;
            r_grant_oh <= '0;
            r_arvalid  <= 1'b0;
            r_araddr   <= '0;
            r_arlen    <= '0;
`ifdef AXI_RD_ARB_QOS_EN
            r_arqos    <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state    <= ISSUE;
                        r_arvalid  <= 1'b1;
                        r_grant    <= w_grant_idx;
                        r_grant_oh <= w_grant_oh;
                        r_araddr   <= w_addr[w_grant_idx];
                        r_arlen    <= w_len[w_grant_idx];
`ifdef AXI_RD_ARB_QOS_EN
                        r_arqos    <= w_qos[w_grant_idx];
`endif
                    end
                end
                ISSUE: begin
                    if (m_axi.arready) begin
                        r_state   <= IDLE;
                        r_arvalid <= 1'b0;
                        r_rr_ptr  <= (r_grant == IDX_W'(NREQ - 1)) ? '0 : r_grant + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Out-of-range rids are always accepted so a bad slave cannot stall the channel.
    assign w_rid_ok = int'(m_axi.rid) < NREQ;

    always_comb begin
        w_rdy_pad             = '1;
        w_rdy_pad[NREQ-1:0]   = req_rready;
    end

    assign m_axi.rready = w_rdy_pad[m_axi.rid];
    assign w_r_last_hs  = m_axi.rvalid && m_axi.rready && m_axi.rlast && w_rid_ok;

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < NREQ; i++) r_out_cnt[i] <= '0;
            r_err_rid <= 1'b0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                case ({w_inc[i], w_dec[i]})
                    2'b10:   r_out_cnt[i] <= r_out_cnt[i] + 1'b1;
                    2'b01:   if (r_out_cnt[i] != '0) r_out_cnt[i] <= r_out_cnt[i] - 1'b1;
                    default: r_out_cnt[i] <= r_out_cnt[i];
                endcase
            end
            if (m_axi.rvalid && !w_rid_ok) r_err_rid <= 1'b1;
        end
    end

    assign req_arready     = w_inc;
    assign req_rdata       = m_axi.rdata;
    assign req_rlast       = m_axi.rlast;
    assign req_rresp       = m_axi.rresp;
    assign m_axi.arvalid   = r_arvalid;
    assign m_axi.arid      = RID_W'(r_grant);
    assign m_axi.araddr    = r_araddr;
    assign m_axi.arlen     = r_arlen;
    assign m_axi.arsize    = AXI_SIZE_16B;
    assign m_axi.arburst   = AXI_BURST_INCR;
    assign err_rid         = r_err_rid;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_axi_rd_arb.sv
// Directed self-checking bench for axi_rd_arb (NREQ=4, MAX_OUT=2).
// QoS expectations follow AXI_RD_ARB_QOS_EN when the bench is built with it.
module tb_axi_rd_arb;
  import axi_rd_arb_pkg::*;

  localparam int NREQ    = 4;
  localparam int MAX_OUT = 2;

  logic               aclk = 1'b0;
  logic               arst;
  logic [NREQ-1:0]    req_arvalid;
  logic [NREQ*32-1:0] req_araddr;
  logic [NREQ*6-1:0]  req_arlen;
  logic [NREQ*4-1:0]  req_arqos;
  logic [NREQ-1:0]    req_rready;
  logic [NREQ-1:0]    req_arready;
  logic [NREQ-1:0]    req_rvalid;
  logic [127:0]       req_rdata;
  logic               req_rlast;
  logic [1:0]         req_rresp;
  logic               err_rid;
  state_e             dbg_state;

  axi_rd_arb_if m_if ();

  axi_rd_arb #(.NREQ(NREQ), .MAX_OUT(MAX_OUT)) dut (
    .aclk        (aclk),
    .arst        (arst),
    .req_arvalid (req_arvalid),
    .req_araddr  (req_araddr),
    .req_arlen   (req_arlen),
    .req_arqos   (req_arqos),
    .req_arready (req_arready),
    .req_rvalid  (req_rvalid),
    .req_rready  (req_rready),
    .req_rdata   (req_rdata),
    .req_rlast   (req_rlast),
    .req_rresp   (req_rresp),
    .m_axi       (m_if.master),
    .err_rid     (err_rid),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;
  int pend [NREQ];
  logic [3:0] exp_q [$];

  // driver tasks
  task automatic drive_req();
    for (int i = 0; i < NREQ; i++) req_arvalid[i] = (pend[i] > 0);
  endtask

  task automatic set_req(input int i, input logic [31:0] addr, input logic [5:0] len,
                         input logic [3:0] qos);
    req_araddr[32*i +: 32] = addr;
    req_arlen[6*i +: 6]    = len;
    req_arqos[4*i +: 4]    = qos;
  endtask

  task automatic do_reset();
    arst         = 1'b1;
    req_arvalid  = '0;
    req_araddr   = '0;
    req_arlen    = '0;
    req_arqos    = '0;
    req_rready   = '1;
    m_if.arready = 1'b1;
    m_if.rvalid  = 1'b0;
    m_if.rid     = '0;
    m_if.rdata   = '0;
    m_if.rlast   = 1'b0;
    m_if.rresp   = '0;
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    exp_q.delete();
    repeat (2) @(posedge aclk);
    #1 arst = 1'b0;
  endtask

  // scoreboard: AR handshakes popped against exp_q, req_arready checked every cycle
  task automatic run_mon(input int ncyc, input bit chk_gap);
    int last = -1;
    for (int c = 0; c < ncyc; c++) begin
      logic       hs;
      logic [3:0] id;
      logic [3:0] exp_id;
      @(negedge aclk);
      hs = m_if.arvalid && m_if.arready;
      id = m_if.arid;
      total++;
      if (hs) begin
        if (req_arready !== (NREQ'(1) << id)) begin
          bad++;
          $display("FAIL mon_arready got=%b exp=%b", req_arready, NREQ'(1) << id);
        end
      end else if (req_arready !== '0) begin
        bad++;
        $display("FAIL mon_arready_idle got=%b exp=0000", req_arready);
      end
      if (hs) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL ar_order unexpected arid=%0d exp=none", id);
        end else begin
          exp_id = exp_q.pop_front();
          if (id !== exp_id) begin
            bad++;
            $display("FAIL ar_order got=%0d exp=%0d", id, exp_id);
          end
        end
        if (chk_gap && last >= 0) begin
          total++;
          if (c - last != 2) begin
            bad++;
            $display("FAIL ar_gap got=%0d exp=2", c - last);
          end
        end
        last = c;
      end
      @(posedge aclk);
      #1;
      if (hs && id < NREQ && pend[id] > 0) pend[id]--;
      drive_req();
    end
  endtask

  task automatic check_q_empty(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s pending_arids got=%0d exp=0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    arst = 1'b1;
    @(negedge aclk);
    total += 10;
    if (m_if.arvalid !== 1'b0)   begin bad++; $display("FAIL rst_arvalid got=%b exp=0", m_if.arvalid); end
    if (m_if.arid !== 4'd0)      begin bad++; $display("FAIL rst_arid got=%0d exp=0", m_if.arid); end
    if (m_if.araddr !== 32'd0)   begin bad++; $display("FAIL rst_araddr got=%h exp=0", m_if.araddr); end
    if (m_if.arlen !== 6'd0)     begin bad++; $display("FAIL rst_arlen got=%0d exp=0", m_if.arlen); end
    if (m_if.arqos !== 4'd0)     begin bad++; $display("FAIL rst_arqos got=%0d exp=0", m_if.arqos); end
    if (req_arready !== 4'b0000) begin bad++; $display("FAIL rst_req_arready got=%b exp=0000", req_arready); end
    if (err_rid !== 1'b0)        begin bad++; $display("FAIL rst_err_rid got=%b exp=0", err_rid); end
    if (dbg_state !== IDLE)      begin bad++; $display("FAIL rst_state got=%0d exp=IDLE", dbg_state); end
    if (m_if.arsize !== 3'b100)  begin bad++; $display("FAIL rst_arsize got=%b exp=100", m_if.arsize); end
    if (m_if.arburst !== 2'b01)  begin bad++; $display("FAIL rst_arburst got=%b exp=01", m_if.arburst); end
    @(posedge aclk);
    #1 arst = 1'b0;
  endtask

  task automatic test_single();
    logic [127:0] d;
    do_reset();
    set_req(0, 32'h0000_1000, 6'd3, 4'd0);
    req_arvalid[0] = 1'b1;
    @(negedge aclk);
    total++;
    if (m_if.arvalid !== 1'b0) begin bad++; $display("FAIL single_latency got=%b exp=0", m_if.arvalid); end
    @(posedge aclk); #1;
    @(negedge aclk);
    total += 5;
    if (m_if.arvalid !== 1'b1)         begin bad++; $display("FAIL single_arvalid got=%b exp=1", m_if.arvalid); end
    if (m_if.arid !== 4'd0)            begin bad++; $display("FAIL single_arid got=%0d exp=0", m_if.arid); end
    if (m_if.araddr !== 32'h0000_1000) begin bad++; $display("FAIL single_araddr got=%h exp=00001000", m_if.araddr); end
    if (m_if.arlen !== 6'd3)           begin bad++; $display("FAIL single_arlen got=%0d exp=3", m_if.arlen); end
    if (req_arready !== 4'b0001)       begin bad++; $display("FAIL single_req_arready got=%b exp=0001", req_arready); end
    @(posedge aclk); #1;
    req_arvalid[0] = 1'b0;
    @(negedge aclk);
    total++;
    if (m_if.arvalid !== 1'b0) begin bad++; $display("FAIL single_arvalid_drop got=%b exp=0", m_if.arvalid); end
    for (int k = 0; k < 4; k++) begin
      d = {4{32'hA5A5_0000 + 32'(k)}};
      m_if.rvalid = 1'b1;
      m_if.rid    = 4'd0;
      m_if.rdata  = d;
      m_if.rlast  = (k == 3);
      m_if.rresp  = 2'(k);
      @(negedge aclk);
      total += 5;
      if (req_rvalid !== 4'b0001)   begin bad++; $display("FAIL beat_rvalid k=%0d got=%b exp=0001", k, req_rvalid); end
      if (m_if.rready !== 1'b1)     begin bad++; $display("FAIL beat_rready k=%0d got=%b exp=1", k, m_if.rready); end
      if (req_rdata !== d)          begin bad++; $display("FAIL beat_rdata k=%0d got=%h exp=%h", k, req_rdata, d); end
      if (req_rlast !== (k == 3))   begin bad++; $display("FAIL beat_rlast k=%0d got=%b exp=%b", k, req_rlast, k == 3); end
      if (req_rresp !== 2'(k))      begin bad++; $display("FAIL beat_rresp k=%0d got=%0d exp=%0d", k, req_rresp, k); end
      @(posedge aclk); #1;
    end
    m_if.rvalid = 1'b0;
    m_if.rlast  = 1'b0;
    // counter back at 0: two further bursts must both be granted
    pend[0] = 2;
    drive_req();
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd0);
    run_mon(8, 1'b0);
    check_q_empty("single_cnt_return");
  endtask

  task automatic test_fairness();
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      set_req(i, 32'h1000 * (i + 1), 6'(i), 4'd0);
      pend[i] = 2;
    end
    drive_req();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++) exp_q.push_back(4'(i));
    run_mon(20, 1'b1);
    check_q_empty("fairness");
  endtask

  task automatic test_back_pressure();
    do_reset();
    m_if.arready = 1'b0;
    set_req(2, 32'h0000_2200, 6'd7, 4'd0);
    req_arvalid[2] = 1'b1;
    @(posedge aclk); #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      total += 5;
      if (m_if.arvalid !== 1'b1)         begin bad++; $display("FAIL bp_arvalid k=%0d got=%b exp=1", k, m_if.arvalid); end
      if (m_if.arid !== 4'd2)            begin bad++; $display("FAIL bp_arid k=%0d got=%0d exp=2", k, m_if.arid); end
      if (m_if.araddr !== 32'h0000_2200) begin bad++; $display("FAIL bp_araddr k=%0d got=%h exp=00002200", k, m_if.araddr); end
      if (m_if.arlen !== 6'd7)           begin bad++; $display("FAIL bp_arlen k=%0d got=%0d exp=7", k, m_if.arlen); end
      if (req_arready !== 4'b0000)       begin bad++; $display("FAIL bp_req_arready k=%0d got=%b exp=0000", k, req_arready); end
      @(posedge aclk); #1;
    end
    m_if.arready = 1'b1;
    @(negedge aclk);
    total++;
    if (req_arready !== 4'b0100) begin bad++; $display("FAIL bp_accept got=%b exp=0100", req_arready); end
    @(posedge aclk); #1;
    req_arvalid[2] = 1'b0;
    @(negedge aclk);
    total++;
    if (m_if.arvalid !== 1'b0) begin bad++; $display("FAIL bp_done got=%b exp=0", m_if.arvalid); end
  endtask

  task automatic test_outstanding();
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h4000 + 32'(i * 16), 6'd1, 4'd0);
    pend[0] = 1; pend[1] = 3; pend[3] = 1;
    drive_req();
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd3);
    exp_q.push_back(4'd1);
    run_mon(14, 1'b0);
    check_q_empty("limit_others_win");
    total++;
    if (pend[1] != 1) begin bad++; $display("FAIL limit_withheld got=%0d exp=1", pend[1]); end
    // one rlast for rid 1 frees a slot, visible to arbitration one cycle later
    m_if.rvalid = 1'b1; m_if.rid = 4'd1; m_if.rlast = 1'b1;
    @(negedge aclk);
    total += 3;
    if (req_rvalid !== 4'b0010) begin bad++; $display("FAIL limit_rvalid got=%b exp=0010", req_rvalid); end
    if (m_if.rready !== 1'b1)   begin bad++; $display("FAIL limit_rready got=%b exp=1", m_if.rready); end
    if (m_if.arvalid !== 1'b0)  begin bad++; $display("FAIL limit_still_blocked got=%b exp=0", m_if.arvalid); end
    @(posedge aclk); #1;
    m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
    @(negedge aclk);
    total++;
    if (m_if.arvalid !== 1'b0) begin bad++; $display("FAIL limit_next_cycle got=%b exp=0", m_if.arvalid); end
    @(posedge aclk); #1;
    m_if.rvalid = 1'b1; m_if.rid = 4'd1; m_if.rlast = 1'b1;
    @(negedge aclk);
    total += 3;
    if (m_if.arvalid !== 1'b1)   begin bad++; $display("FAIL limit_reenable got=%b exp=1", m_if.arvalid); end
    if (m_if.arid !== 4'd1)      begin bad++; $display("FAIL limit_reenable_id got=%0d exp=1", m_if.arid); end
    if (req_arready !== 4'b0010) begin bad++; $display("FAIL limit_reenable_rdy got=%b exp=0010", req_arready); end
    @(posedge aclk); #1;
    // AR accept and rlast landed on the same edge: count stays at 1, so exactly one more fits
    m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
    pend[1] = 2;
    drive_req();
    exp_q.push_back(4'd1);
    run_mon(12, 1'b0);
    check_q_empty("same_cycle_keep");
    total++;
    if (pend[1] != 1) begin bad++; $display("FAIL same_cycle_withheld got=%0d exp=1", pend[1]); end
  endtask

  task automatic test_bad_rid();
    do_reset();
    req_rready  = 4'b0000;
    m_if.rvalid = 1'b1; m_if.rid = 4'd7; m_if.rlast = 1'b1;
    @(negedge aclk);
    total += 3;
    if (m_if.rready !== 1'b1)   begin bad++; $display("FAIL badrid_rready got=%b exp=1", m_if.rready); end
    if (req_rvalid !== 4'b0000) begin bad++; $display("FAIL badrid_rvalid got=%b exp=0000", req_rvalid); end
    if (err_rid !== 1'b0)       begin bad++; $display("FAIL badrid_err_early got=%b exp=0", err_rid); end
    @(posedge aclk); #1;
    m_if.rid = 4'd3; m_if.rlast = 1'b0;
    @(negedge aclk);
    total += 3;
    if (err_rid !== 1'b1)       begin bad++; $display("FAIL badrid_err got=%b exp=1", err_rid); end
    if (m_if.rready !== 1'b0)   begin bad++; $display("FAIL route_rready got=%b exp=0", m_if.rready); end
    if (req_rvalid !== 4'b1000) begin bad++; $display("FAIL route_rvalid got=%b exp=1000", req_rvalid); end
    @(posedge aclk); #1;
    m_if.rvalid = 1'b0;
    req_rready  = '1;
    @(negedge aclk);
    total++;
    if (err_rid !== 1'b1) begin bad++; $display("FAIL badrid_sticky got=%b exp=1", err_rid); end
  endtask

  task automatic test_async_reset();
    do_reset();
    m_if.arready = 1'b0;
    set_req(3, 32'h0000_3300, 6'd2, 4'd0);
    req_arvalid[3] = 1'b1;
    @(posedge aclk); #1;
    @(negedge aclk);
    total += 2;
    if (m_if.arvalid !== 1'b1) begin bad++; $display("FAIL arst_pre_arvalid got=%b exp=1", m_if.arvalid); end
    if (dbg_state !== ISSUE)   begin bad++; $display("FAIL arst_pre_state got=%0d exp=ISSUE", dbg_state); end
    arst = 1'b1;
    #1;
    total += 3;
    if (m_if.arvalid !== 1'b0) begin bad++; $display("FAIL arst_arvalid got=%b exp=0", m_if.arvalid); end
    if (dbg_state !== IDLE)    begin bad++; $display("FAIL arst_state got=%0d exp=IDLE", dbg_state); end
    if (m_if.araddr !== 32'd0) begin bad++; $display("FAIL arst_araddr got=%h exp=0", m_if.araddr); end
    req_arvalid = '0;
    @(posedge aclk); #1;
    arst = 1'b0;
  endtask

  task automatic test_qos();
    do_reset();
    set_req(0, 32'h0000_00A0, 6'd1, 4'd1);
    set_req(2, 32'h0000_00C0, 6'd1, 4'd8);
    req_arvalid = 4'b0101;
    @(posedge aclk); #1;
    @(negedge aclk);
    total += 2;
`ifdef AXI_RD_ARB_QOS_EN
    if (m_if.arid !== 4'd2)  begin bad++; $display("FAIL qos_arid got=%0d exp=2", m_if.arid); end
    if (m_if.arqos !== 4'd8) begin bad++; $display("FAIL qos_arqos got=%0d exp=8", m_if.arqos); end
`else
    if (m_if.arid !== 4'd0)  begin bad++; $display("FAIL qos_arid got=%0d exp=0", m_if.arid); end
    if (m_if.arqos !== 4'd0) begin bad++; $display("FAIL qos_arqos got=%0d exp=0", m_if.arqos); end
`endif
    req_arvalid = '0;
    @(posedge aclk); #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_back_pressure();
    test_outstanding();
    test_bad_rid();
    test_async_reset();
    test_qos();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
